// File: rtl/osc_meas_pkg.sv
// Shared types and default constants for the oscillator measurement controller.
package osc_meas_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCount,
    StDone
  } state_e;

  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned WinWDefault       = 16;
  localparam int unsigned SettleCycDefault  = 8;
  localparam int unsigned SyncStagesDefault = 2;

endpackage

// File: rtl/cmp_sync_edge.sv
// Synchronizes the asynchronous comparator output and emits a registered
// one-cycle pulse per rising edge; edge-to-pulse latency is SYNC_STAGES+1.
module cmp_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst,
  input  logic cmp_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   shift;
  logic                   prev_q;
  logic                   pulse_q;

  assign shift = {sync_q, cmp_i};

  // Synchronizer chain, previous-value flop and registered edge pulse.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= shift[SYNC_STAGES-1:0];
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/osc_meas_ctrl.sv
// Relaxation-oscillator measurement sequencer: discharge, count comparator
// edges over a programmable window while ping-ponging the capacitor selects,
// then present the count with a valid/ready handshake.
module osc_meas_ctrl
  import osc_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned WIN_W       = WinWDefault,
  parameter int unsigned SETTLE_CYC  = SettleCycDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  output logic             osc_en,
  output logic             rst_osc,
  output logic             sel_cap1,
  output logic             sel_cap2,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [WIN_W-1:0] SettleLast = WIN_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sel1_q, sel1_d;
  logic             sel2_q, sel2_d;
  logic             dead_q, dead_d;  // both selects low, swap in flight
  logic             pend_q, pend_d;  // one further swap queued behind it
  logic             to2_q, to2_d;    // select to raise when the dead cycle ends
  logic             pulse;

  cmp_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cmp_sync_edge (
    .clk_i  (clk),
    .rst    (rst),
    .cmp_i  (cmp),
    .pulse_o(pulse)
  );

  // State, counters and capacitor-select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      win_q   <= WIN_W'(1);
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sel1_q  <= 1'b1;
      sel2_q  <= 1'b0;
      dead_q  <= 1'b0;
      pend_q  <= 1'b0;
      to2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      dead_q  <= dead_d;
      pend_q  <= pend_d;
      to2_q   <= to2_d;
    end
  end

  // Next-state: sequencing, saturating edge count and break-before-make swaps.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sel1_d  = sel1_q;
    sel2_d  = sel2_q;
    dead_d  = dead_q;
    pend_d  = pend_q;
    to2_d   = to2_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          win_d   = (win_len == '0) ? WIN_W'(1) : win_len;
          cyc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StSettle: begin
        if (cyc_q == SettleLast) begin
          state_d = StCount;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + WIN_W'(1);
        end
      end
      StCount: begin
        if (pulse) begin
          if (cnt_q == CntMax) ovf_d = 1'b1;
          else                 cnt_d = cnt_q + CNT_W'(1);
        end
        if (dead_q) begin
          sel1_d = ~to2_q;
          sel2_d = to2_q;
          dead_d = 1'b0;
          pend_d = pend_q | pulse;
        end else if (pulse || pend_q) begin
          to2_d  = sel1_q;
          sel1_d = 1'b0;
          sel2_d = 1'b0;
          dead_d = 1'b1;
          pend_d = 1'b0;
        end
        if (cyc_q == win_q - WIN_W'(1)) begin
          state_d = StDone;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + WIN_W'(1);
        end
      end
      StDone: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end

    // Outside the counting window the selects rest at cap1.
    if (state_d != StCount) begin
      sel1_d = 1'b1;
      sel2_d = 1'b0;
      dead_d = 1'b0;
      pend_d = 1'b0;
    end
  end

  assign osc_en       = (state_q == StSettle) || (state_q == StCount);
  assign rst_osc      = (state_q != StCount);
  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StDone);
  assign result       = cnt_q;
  assign overflow     = ovf_q;
  assign sel_cap1     = sel1_q;
  assign sel_cap2     = sel2_q;

endmodule

// File: tb/tb_osc_meas_ctrl.sv
// Directed bench for osc_meas_ctrl: a table of measurement vectors plus
// hand-written abort, reset and DONE-hold sequences.
module tb_osc_meas_ctrl;

  localparam int CW = 4;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst, cmp, start, abort, result_ready;
  logic [WW-1:0] win_len;
  logic          osc_en, rst_osc, sel_cap1, sel_cap2, busy, result_valid, overflow;
  logic [CW-1:0] result;

  osc_meas_ctrl #(
    .CNT_W(CW),
    .WIN_W(WW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmp         (cmp),
    .start       (start),
    .abort       (abort),
    .win_len     (win_len),
    .osc_en      (osc_en),
    .rst_osc     (rst_osc),
    .sel_cap1    (sel_cap1),
    .sel_cap2    (sel_cap2),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    win;
    int    half;  // cmp half period in cycles; 0 = held low, -1 = random
    int    res;   // -1 = do not check the count
    int    ovf;
  } meas_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Comparator stimulus, changed on the falling edge.
  int cmp_half = 0;
  initial begin
    int ph;
    ph  = 0;
    cmp = 1'b0;
    forever begin
      @(negedge clk);
      if (cmp_half < 0) begin
        cmp = 1'($urandom_range(0, 1));
      end else if (cmp_half == 0) begin
        cmp = 1'b0;
        ph  = 0;
      end else begin
        ph++;
        if (ph >= cmp_half) begin
          cmp = ~cmp;
          ph  = 0;
        end
      end
    end
  end

  // Select monitor: overlap count and length of every both-low run.
  int overlap_cnt = 0;
  int bad_run     = 0;
  int swaps       = 0;
  initial begin
    int zrun;
    zrun = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sel_cap1 && sel_cap2) overlap_cnt++;
        if (!sel_cap1 && !sel_cap2) begin
          zrun++;
        end else if (zrun != 0) begin
          if (zrun != 1) bad_run++;
          swaps++;
          zrun = 0;
        end
      end
    end
  end

  task automatic run_meas(input meas_t v);
    int e, weff, s0, ds;
    logic [CW-1:0] held;
    weff     = (v.win == 0) ? 1 : v.win;
    cmp_half = v.half;
    repeat (20) @(negedge clk);
    win_len = WW'(v.win);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s0    = swaps;
    chk({v.name, "_settle_outs"}, {28'd0, busy, osc_en, rst_osc, result_valid}, 32'b1110);
    e = 1;
    while (!result_valid && e < weff + 40) begin
      @(negedge clk);
      e++;
      if (e == 9) chk({v.name, "_count_outs"}, {30'd0, osc_en, rst_osc}, 32'b10);
    end
    chk({v.name, "_latency"}, e, 9 + weff);
    chk({v.name, "_done_outs"}, {27'd0, osc_en, rst_osc, sel_cap1, sel_cap2, busy},
        32'b01101);
    if (v.res >= 0) begin
      chk({v.name, "_result"}, {28'd0, result}, v.res);
      chk({v.name, "_overflow"}, {31'd0, overflow}, v.ovf);
    end
    held = result;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk({v.name, "_hold"}, {27'd0, result_valid, result}, {27'd0, 1'b1, held});
    if (v.res >= 0 && v.ovf == 0) begin
      ds = swaps - s0;
      chk({v.name, "_swaps"}, (ds == v.res || ds == v.res - 1) ? 1 : 0, 1);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({v.name, "_after_hs"}, {30'd0, result_valid, busy}, 0);
  endtask

  meas_t vecs[7];

  initial begin
    int e, stable_bad, seen;
    logic [CW-1:0] held;

    vecs[0] = '{"p10_w100", 100,  5, 10, 0};
    vecs[1] = '{"p10_w150", 150,  5, 15, 0};
    vecs[2] = '{"sat_w200", 200,  5, 15, 1};
    vecs[3] = '{"p4_w40",    40,  2, 10, 0};
    vecs[4] = '{"p2_w20",    20,  1, 10, 0};
    vecs[5] = '{"w0_quiet",   0,  0,  0, 0};
    vecs[6] = '{"rand_w60",  60, -1, -1, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; result_ready = 1'b0; win_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {25'd0, osc_en, rst_osc, sel_cap1, sel_cap2, busy, result_valid,
        overflow}, 32'b0110000);
    chk("reset_result", {28'd0, result}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_meas(vecs[i]);

    // Abort beats a simultaneous start.
    start = 1'b1; abort = 1'b1; win_len = 16'd10;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_vs_start", {31'd0, busy}, 0);

    // Abort in the fifth COUNT cycle.
    cmp_half = 5;
    repeat (20) @(negedge clk);
    win_len = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_in_count", {30'd0, osc_en, rst_osc}, 32'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_outs", {26'd0, busy, osc_en, rst_osc, result_valid, sel_cap1, sel_cap2},
        32'b001010);
    seen = 0;
    repeat (120) begin
      @(negedge clk);
      if (result_valid || busy) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run_meas(vecs[0]);

    // Asynchronous reset in the middle of COUNT.
    win_len = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", {25'd0, osc_en, rst_osc, sel_cap1, sel_cap2, busy, result_valid,
        overflow}, 32'b0110000);
    chk("rst_async_result", {28'd0, result}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (result_valid || busy) seen++;
    end
    chk("rst_no_valid", seen, 0);

    // start held through DONE with result_ready low is ignored.
    cmp_half = 5;
    repeat (20) @(negedge clk);
    win_len = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = 1;
    while (!result_valid && e < 200) begin
      @(negedge clk);
      e++;
    end
    chk("done_hold_latency", e, 109);
    chk("done_hold_result", {28'd0, result}, 10);
    held = result;
    stable_bad = 0;
    start = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!result_valid || result !== held || overflow !== 1'b0) stable_bad++;
    end
    start = 1'b0;
    chk("done_hold_stable", stable_bad, 0);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    seen = 0;
    repeat (5) begin
      if (busy || result_valid) seen++;
      @(negedge clk);
    end
    chk("start_not_queued", seen, 0);

    chk("sel_no_overlap", overlap_cnt, 0);
    chk("sel_dead_cycle_len", bad_run, 0);
    chk("sel_swaps_seen", (swaps > 0) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/osc_meas_ctrl.md
OSC_MEAS_CTRL -- requirements
Module: osc_meas_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the pulse count and result.
REQ-002 Parameter WIN_W, default 16, width of the measurement window length.
REQ-003 Parameter SETTLE_CYC, default 8, clk cycles spent discharging the capacitors before counting.
REQ-004 Parameter SYNC_STAGES, default 2, flops in the cmp synchronizer.
REQ-005 clk  in  1  system clock; all state is on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 cmp  in  1  comparator output, asynchronous to clk.
REQ-008 start  in  1  one-cycle request to begin a measurement.
REQ-009 abort  in  1  synchronous cancel of any measurement in progress.
REQ-010 win_len  in  WIN_W  count-window length in clk cycles; sampled on an accepted start.
REQ-011 osc_en  out  1  enables the comparator/oscillator.
REQ-012 rst_osc  out  1  discharges both capacitors.
REQ-013 sel_cap1, sel_cap2  out  1 each  non-overlapping capacitor selects.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 result  out  CNT_W  count of cmp rising edges in the window.
REQ-016 result_valid  out  1  result is available.
REQ-017 result_ready  in  1  consumer accepts the result.
REQ-018 overflow  out  1  count saturated during the window; valid with result.

Function
REQ-019 FSM states SHALL be IDLE, SETTLE, COUNT and DONE.
REQ-020 IDLE: osc_en=0, rst_osc=1, sel_cap1=1, sel_cap2=0; start=1 SHALL latch win_len (0 treated as 1) and go to SETTLE on the next cycle.
REQ-021 SETTLE: osc_en=1, rst_osc=1 for exactly SETTLE_CYC cycles, then COUNT; the count and overflow SHALL clear on entry.
REQ-022 COUNT: rst_osc=0 for exactly the latched window cycles; after the last window cycle the FSM SHALL go to DONE.
REQ-023 Edge detect: a rising edge on the synchronized cmp SHALL produce a one-cycle pulse; latency from the cmp edge to the pulse is SYNC_STAGES+1 cycles.
REQ-024 Each pulse in COUNT, including the final window cycle, SHALL increment the count.
REQ-025 The count SHALL saturate at 2^CNT_W-1 and set overflow; it never wraps.
REQ-026 Each pulse in COUNT SHALL start a cap swap: the active select falls immediately, both selects stay 0 for one cycle, then the other select rises.
REQ-027 sel_cap1 and sel_cap2 SHALL never be 1 in the same cycle.
REQ-028 A pulse arriving during the dead cycle SHALL be counted and swap the caps again once the current swap completes; at most one swap is pending.
REQ-029 Pulses in IDLE, SETTLE or DONE SHALL be ignored.
REQ-030 DONE: osc_en=0, rst_osc=1, selects at IDLE values, result_valid=1; result and overflow SHALL hold stable until result_valid and result_ready are both 1.
REQ-031 On the handshake the FSM SHALL return to IDLE, and result_valid SHALL drop on the next cycle.
REQ-032 start outside IDLE SHALL be ignored; it is not queued.
REQ-033 abort SHALL force IDLE on the next cycle from any state and discard the result; abort wins over a simultaneous start or handshake.

Reset
REQ-034 rst=1 SHALL immediately force IDLE with IDLE output values, busy=0, result=0, result_valid=0 and overflow=0, and SHALL clear the synchronizer flops.
REQ-035 Reset mid-measurement SHALL discard all progress; no result_valid after reset deasserts without a new start.

Structure
REQ-036 Package osc_meas_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-037 The synchronizer plus rising-edge detector SHALL be the sub-module cmp_sync_edge.

Verification
REQ-038 win_len=100, cmp square wave with a 10-cycle period -> result=10, overflow=0, result_valid held until result_ready.
REQ-039 CNT_W=4, 20 cmp edges in the window -> result=15, overflow=1.
REQ-040 Random cmp on every COUNT cycle -> sel_cap1&sel_cap2 never 1; each swap has exactly one cycle with both selects 0.
REQ-041 abort in cycle 5 of COUNT -> IDLE next cycle, no result_valid; a following start works normally.
REQ-042 rst pulse during COUNT -> all outputs at reset values asynchronously, busy=0.
REQ-043 start during DONE with result_ready=0 for 50 cycles -> ignored, result stable; win_len=0 -> one-cycle window.
